// File: rtl/axis_i2c_tx_fifo.sv
// axis_i2c_tx_fifo: first-word-fall-through AXI-Stream FIFO with occupancy and full/empty/almost-full flags
package axis_i2c_pkg;
  localparam int AXIS_DATA_WIDTH = 8;
endpackage

module axis_i2c_tx_fifo #(
  parameter int DATA_WIDTH      = axis_i2c_pkg::AXIS_DATA_WIDTH,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = DEPTH - 2,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [AW:0]           count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o
);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic push, pop;
  always_comb begin
    count_o       = wr_ptr_q - rd_ptr_q;
    empty_o       = wr_ptr_q == rd_ptr_q;
    full_o        = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    almost_full_o = count_o >= (AW+1)'(ALMOST_FULL_LVL);
    s_axis_tready = !full_o;
    m_axis_tvalid = !empty_o;
    m_axis_tdata  = mem_q[rd_ptr_q[AW-1:0]];
    push          = s_axis_tvalid && s_axis_tready;
    pop           = m_axis_tvalid && m_axis_tready;
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_axis_tdata;
  end
endmodule

// File: tb/tb_axis_i2c_tx_fifo.sv
// tb_axis_i2c_tx_fifo: randomized scoreboard bench for the AXIS FIFO against a queue model
module tb_axis_i2c_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;
  logic       clk_i = 0;
  logic       arst_i = 1;
  logic [7:0] s_axis_tdata = 0;
  logic       s_axis_tvalid = 0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 0;
  logic [4:0] count_o;
  logic       full_o, empty_o, almost_full_o;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q [$];
  logic       last_acc = 0;
  logic       hold_v = 0;
  logic [7:0] hold_d = 0;
  axis_i2c_tx_fifo dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask
  // reference model: word accepted when producer valid and the model holds fewer than DEPTH words
  always @(posedge clk_i) begin
    if (!arst_i) begin
      automatic int  sz  = exp_q.size();
      automatic bit  acc = s_axis_tvalid && sz < DEPTH;
      if (m_axis_tready && sz > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(s_axis_tdata);
      last_acc = acc;
    end
  end
  always @(negedge clk_i) begin
    automatic int sz = exp_q.size();
    chk("count", count_o, sz);
    chk("empty", empty_o, sz == 0);
    chk("full", full_o, sz == DEPTH);
    chk("almost_full", almost_full_o, sz >= AFL);
    chk("s_tready", s_axis_tready, sz < DEPTH);
    chk("m_tvalid", m_axis_tvalid, sz > 0);
    if (hold_v) chk("tdata_stable", m_axis_tdata, hold_d);
    if (m_axis_tvalid && m_axis_tready && sz > 0) chk("tdata", m_axis_tdata, exp_q[0]);
    hold_v = m_axis_tvalid && !m_axis_tready && !arst_i;
    hold_d = m_axis_tdata;
  end
  task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
    @(posedge clk_i);
    #1;
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    m_axis_tready = mr;
  endtask
  task automatic async_reset();
    @(negedge clk_i);
    #2;
    arst_i = 1;
    exp_q.delete();
    hold_v = 0;
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_afull", almost_full_o, 0);
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    s_axis_tvalid = 0;
    m_axis_tready = 0;
    @(negedge clk_i);
    #1;
    arst_i = 0;
  endtask
  initial begin
    async_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0);
    for (int i = 0; i < 3; i++) step(1, 8'h10, 0);
    step(0, 0, 0);
    #1;
    chk("fill_count", count_o, DEPTH);
    chk("fill_full", full_o, 1);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1);
    #1;
    chk("drain_empty", empty_o, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 40; i++) step(1, 8'(8'h80 + i), 1);
    step(0, 0, 0);
    #1;
    chk("pp_count", count_o, 5);
    for (int i = 0; i < 400; i++) begin
      automatic logic v = (s_axis_tvalid && !last_acc) ? 1'b1 : 1'($urandom_range(0, 1));
      automatic logic [7:0] d = (s_axis_tvalid && !last_acc) ? s_axis_tdata : 8'($urandom);
      step(v, d, $urandom_range(0, 9) < 3);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 8'(8'hC0 + i), 0);
    step(0, 0, 0);
    #1;
    chk("pre_rst_count", count_o, 9);
    async_reset();
    step(1, 8'hA5, 0);
    step(0, 0, 1);
    #1;
    chk("post_rst_head", m_axis_tdata, 8'hA5);
    step(0, 0, 1);
    step(0, 0, 0);
    @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
